// File: rtl/game_pkg.sv
// Shared types and constants for the typing-game flow controller.
// Holds the FSM state encoding, key codes, result codes and level lengths.
// Pure declarations: no logic and no timing.
package game_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_INTRO = 3'd1,
    ST_TYPE  = 3'd2,
    ST_CHECK = 3'd3,
    ST_WIN   = 3'd4,
    ST_FAIL  = 3'd5,
    ST_DONE  = 3'd6
  } state_t;

  localparam int TIMER_W = 28;

  localparam logic [7:0] KEY_ENTER    = 8'h0D;
  localparam logic [7:0] KEY_ESC      = 8'h1B;
  localparam logic [7:0] KEY_PRINT_LO = 8'h20;
  localparam logic [7:0] KEY_PRINT_HI = 8'h7E;

  localparam logic [1:0] RES_NONE = 2'b00;
  localparam logic [1:0] RES_WIN  = 2'b01;
  localparam logic [1:0] RES_FAIL = 2'b10;
  localparam logic [1:0] RES_DONE = 2'b11;

  // Characters per level; level 1 is "BU ENGINEERING". The fourth entry only
  // matters for a four-level build and mirrors level 2 until one is written.
  localparam logic [7:0] LEVEL_LEN [4] = '{8'd5, 8'd14, 8'd9, 8'd9};

  function automatic logic is_printable(input logic [7:0] k);
    return (k >= KEY_PRINT_LO) && (k <= KEY_PRINT_HI);
  endfunction

endpackage

// File: rtl/dwell_timer.sv
// Down-counter that times how long the FSM dwells in a state.
// Latency: load takes effect at the next edge; expired is a decode of the count.
// No backpressure: counts down every cycle and holds at zero.
module dwell_timer
  import game_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [TIMER_W-1:0] value,
  output logic               expired
);

  logic [TIMER_W-1:0] count;

  // Reload on state entry, otherwise count down to zero and stay there.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/level_sequencer.sv
// Game-flow FSM: intro, typing, win check and result screens per level.
// Latency: every output is registered and reflects the key/flag sampled one edge earlier.
// No backpressure: keys arriving in states that do not use them are dropped.
module level_sequencer
  import game_pkg::*;
#(
  parameter int NUM_LEVELS    = 3,
  parameter int INTRO_CYCLES  = 100_000_000,
  parameter int RESULT_CYCLES = 200_000_000,
  parameter int CHECK_CYCLES  = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_valid,
  input  logic [7:0] key_ascii,
  input  logic       lvl_won,
  output logic [1:0] level,
  output logic [7:0] letter,
  output logic [7:0] counter,
  output logic       level_reset,
  output logic       show_intro,
  output logic [1:0] show_result,
  output logic [2:0] state_dbg
);

  state_t             state, state_next;
  logic [1:0]         level_next;
  logic [7:0]         letter_next, counter_next;
  logic [7:0]         len;
  logic               entering_intro;
  logic               timer_load, timer_expired;
  logic [TIMER_W-1:0] timer_value;

  assign len       = LEVEL_LEN[level];
  assign state_dbg = state;

  dwell_timer u_timer (
    .clk     (clk),
    .reset   (reset),
    .load    (timer_load),
    .value   (timer_value),
    .expired (timer_expired)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Next-state, key handling and timer load value.
  always_comb begin
    state_next   = state;
    level_next   = level;
    letter_next  = letter;
    counter_next = counter;
    case (state)
      ST_IDLE:  if (key_valid) state_next = ST_INTRO;
      ST_INTRO: if (timer_expired) state_next = ST_TYPE;
      ST_TYPE: begin
        if (key_valid) begin
          if (key_ascii == KEY_ESC) begin
            state_next = ST_INTRO;
          end else if (key_ascii == KEY_ENTER && counter == len) begin
            // L+1 is the submit code the displays look for.
            counter_next = len + 8'd1;
            state_next   = ST_CHECK;
          end else if (is_printable(key_ascii) && counter < len) begin
            letter_next  = key_ascii;
            counter_next = counter + 8'd1;
          end
        end
      end
      ST_CHECK: begin
        if (lvl_won)            state_next = ST_WIN;
        else if (timer_expired) state_next = ST_FAIL;
      end
      ST_WIN: begin
        if (timer_expired) begin
          if (level == 2'(NUM_LEVELS - 1)) begin
            state_next = ST_DONE;
          end else begin
            level_next = level + 2'd1;
            state_next = ST_INTRO;
          end
        end
      end
      ST_FAIL: if (timer_expired) state_next = ST_INTRO;
      ST_DONE: begin
        if (key_valid) begin
          state_next = ST_IDLE;
          level_next = 2'd0;
        end
      end
      default: state_next = ST_IDLE;
    endcase

    entering_intro = (state_next == ST_INTRO) && (state != ST_INTRO);
    if (entering_intro) begin
      counter_next = 8'd0;
      letter_next  = 8'h00;
    end

    // Timer value is one less than the dwell so the state lasts exactly N cycles.
    timer_load = (state_next != state);
    case (state_next)
      ST_INTRO:        timer_value = TIMER_W'(INTRO_CYCLES - 1);
      ST_CHECK:        timer_value = TIMER_W'(CHECK_CYCLES - 1);
      ST_WIN, ST_FAIL: timer_value = TIMER_W'(RESULT_CYCLES - 1);
      default:         timer_value = '0;
    endcase
  end

  // Datapath and registered screen controls; level_reset holds high out of reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      level       <= 2'd0;
      letter      <= 8'h00;
      counter     <= 8'd0;
      level_reset <= 1'b1;
      show_intro  <= 1'b0;
      show_result <= RES_NONE;
    end else begin
      level       <= level_next;
      letter      <= letter_next;
      counter     <= counter_next;
      level_reset <= entering_intro;
      show_intro  <= (state_next == ST_INTRO);
      case (state_next)
        ST_WIN:  show_result <= RES_WIN;
        ST_FAIL: show_result <= RES_FAIL;
        ST_DONE: show_result <= RES_DONE;
        default: show_result <= RES_NONE;
      endcase
    end
  end

endmodule
